acc_matmul_engine: RTL
======================

ACC_MATMUL_ENGINE -- requirements
Module: acc_matmul_engine

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the square matrix dimension; legal values are powers of two from 2 to 32.
REQ-002 The block SHALL have parameter DW, default 8, giving the element width in bits.
REQ-003 The block SHALL have derived localparam AW = clog2(N*N), the element address width; AW is 10 at defaults.
REQ-004 Port: clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 Port: rst_n, input, 1; reset is synchronous and active-low.
REQ-006 Port: start, input, 1, single-cycle request from the host-side bridge to compute C = A x B.
REQ-007 Port: busy_o, output, 1, high while a computation is in progress.
REQ-008 Port: done_o, output, 1, one-cycle completion pulse.
REQ-009 Port: a_addr_o, output, AW, matrix A read address.
REQ-010 Port: a_data_i, input, DW, matrix A read data, valid one cycle after the address.
REQ-011 Port: b_addr_o, output, AW, matrix B read address.
REQ-012 Port: b_data_i, input, DW, matrix B read data, valid one cycle after the address.
REQ-013 Port: c_addr_o, output, AW, matrix C write address.
REQ-014 Port: c_data_o, output, DW, matrix C write data.
REQ-015 Port: c_we_o, output, 1, matrix C write strobe.

Function
REQ-016 Storage SHALL be row-major: A(i,k) is at address i*N+k, B(k,j) at k*N+j, and C(i,j) at i*N+j.
REQ-017 The block SHALL compute C(i,j) = sum over k of A(i,k)*B(k,j), with unsigned operands and an accumulator of 2*DW+clog2(N) bits, so that no overflow is possible.
REQ-018 The written value SHALL saturate: if the accumulator exceeds 2^DW-1, c_data_o SHALL be all ones; otherwise it SHALL be the low DW bits.
REQ-019 The FSM SHALL have the states IDLE, READ, DRAIN, WRITE and DONE.
REQ-020 In IDLE, start=1 SHALL clear i, j, k and the accumulator and move to READ.
REQ-021 READ SHALL last N cycles; each cycle it drives a_addr_o=i*N+k and b_addr_o=k*N+j, and k increments.
REQ-022 The product of the data returned for each k SHALL be added to the accumulator in the following cycle.
REQ-023 DRAIN SHALL last 1 cycle and SHALL accumulate the product for k=N-1.
REQ-024 WRITE SHALL last 1 cycle, with c_we_o=1, c_addr_o=i*N+j and the saturated sum.
REQ-025 After WRITE, the block SHALL clear the accumulator and k, advance j (wrapping to 0 and incrementing i at N), and return to READ.
REQ-026 After the WRITE for element (N-1,N-1), the block SHALL go to DONE instead of READ.
REQ-027 DONE SHALL assert done_o for exactly one cycle and then return to IDLE.
REQ-028 The element period SHALL be N+2 cycles.
REQ-029 If start is sampled in cycle t, the last WRITE SHALL occur at t+N*N*(N+2) and done_o SHALL be high at t+N*N*(N+2)+1.
REQ-030 busy_o SHALL be high from t+1 through the done_o cycle inclusive.
REQ-031 start SHALL be ignored in every state other than IDLE, including DONE; no restart or queuing occurs.
REQ-032 Back-to-back operation: start in the first IDLE cycle after DONE SHALL begin a new computation normally.
REQ-033 c_we_o SHALL be high only in WRITE, exactly N*N times per computation, with each C address written once, in ascending address order.
REQ-034 Outside READ, a_addr_o and b_addr_o SHALL hold their values; the memories ignore them.
REQ-035 Outside WRITE, c_addr_o and c_data_o SHALL be 0.

Reset
REQ-036 rst_n=0 at a rising edge SHALL force IDLE and clear i, j, k and the accumulator.
REQ-037 While reset is applied, busy_o, done_o, c_we_o, a_addr_o, b_addr_o, c_addr_o and c_data_o SHALL all be 0.
REQ-038 Reset mid-operation SHALL abort the computation with no further C writes and no done_o pulse; previously written C elements remain as written.
REQ-039 start asserted in the same cycle as rst_n=0 SHALL be ignored.

Verification
REQ-040 (N=2) A=[1,2;3,4], B=[5,6;7,8], start at t -> C writes 19,22,43,50 at addresses 0..3, at t+4, t+8, t+12, t+16; done_o at t+17.
REQ-041 (N=4) A=identity, B(k,j)=k*4+j -> C equals B; exactly 16 writes; done_o at t+97.
REQ-042 (N=4) all A and B elements 255 -> every C value is 255 (saturation), with no wrap artefacts.
REQ-043 (N=2) start pulsed again at t+5 and at t+17 -> both ignored; one done_o only; start at t+18 begins a second run, with done_o at t+35.
REQ-044 (N=4) rst_n=0 at t+30 -> busy_o=0 next cycle, no further c_we_o, no done_o; a new start after reset completes correctly.
REQ-045 All configurations -> busy_o never low between start and done_o, and c_we_o count equals N*N (checked by assertion).

Source files
------------

// File: rtl/acc_matmul_engine.sv
// Unsigned C = A x B over sync-read memories; one C element per N+2 cycles, done_o at start+N*N*(N+2)+1.
// No backpressure: memories answer one cycle after the address, and start is ignored unless idle.
module acc_matmul_engine #(
  parameter int N  = 32,
  parameter int DW = 8,
  localparam int AW = $clog2(N * N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] a_addr_o,
  input  logic [DW-1:0] a_data_i,
  output logic [AW-1:0] b_addr_o,
  input  logic [DW-1:0] b_data_i,
  output logic [AW-1:0] c_addr_o,
  output logic [DW-1:0] c_data_o,
  output logic          c_we_o
);

  localparam int KW  = $clog2(N);
  localparam int ACW = 2 * DW + KW;

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

  state_t          state, state_nxt;
  logic [KW-1:0]   i_q, j_q, k_q;
  logic [ACW-1:0]  acc_q;
  logic            rd_vld_q;
  logic [AW-1:0]   a_hold_q, b_hold_q;
  logic [2*DW-1:0] prod;
  logic            last_k, last_elem, sat;

  assign last_k    = (k_q == KW'(N - 1));
  assign last_elem = (i_q == KW'(N - 1)) && (j_q == KW'(N - 1));
  assign prod      = {{DW{1'b0}}, a_data_i} * {{DW{1'b0}}, b_data_i};
  assign sat       = |acc_q[ACW-1:DW];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    if (last_k) state_nxt = DRAIN;
      DRAIN:   state_nxt = WRITE;
      WRITE:   state_nxt = last_elem ? DONE : READ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rd_vld_q marks the cycle in which read data for the previous READ cycle is present.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      rd_vld_q <= 1'b0;
      a_hold_q <= '0;
      b_hold_q <= '0;
    end else begin
      rd_vld_q <= (state == READ);
      if (rd_vld_q) acc_q <= acc_q + ACW'(prod);
      case (state)
        IDLE: begin
          if (start) begin
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
          end
        end
        READ: begin
          a_hold_q <= {i_q, k_q};
          b_hold_q <= {k_q, j_q};
          k_q      <= k_q + KW'(1);
        end
        WRITE: begin
          acc_q <= '0;
          k_q   <= '0;
          j_q   <= j_q + KW'(1);
          if (j_q == KW'(N - 1)) i_q <= i_q + KW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy_o   = (state != IDLE);
  assign done_o   = (state == DONE);
  assign c_we_o   = (state == WRITE);
  assign a_addr_o = (state == READ) ? {i_q, k_q} : a_hold_q;
  assign b_addr_o = (state == READ) ? {k_q, j_q} : b_hold_q;
  assign c_addr_o = c_we_o ? {i_q, j_q} : '0;
  assign c_data_o = c_we_o ? (sat ? '1 : acc_q[DW-1:0]) : '0;

endmodule
